// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the nonce-search controller.
//   NONCE_W_DEF : default nonce width in bits
//   HASH_W_DEF  : default hash / target width in bits
//   state_t     : controller state encoding
// -----------------------------------------------------------------------------
package miner_pkg;

   localparam int NONCE_W_DEF = 32;
   localparam int HASH_W_DEF  = 256;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      CHECK  = 3'd3,
      REPORT = 3'd4,
      DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/hash_cmp.sv
// -----------------------------------------------------------------------------
// hash_cmp
// Purely combinational unsigned magnitude comparator.
//   a  : input  W  hash value
//   b  : input  W  threshold
//   lt : output 1  high when a < b (unsigned, full width)
// -----------------------------------------------------------------------------
module hash_cmp
   import miner_pkg::*;
#(
   parameter int W = HASH_W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         lt
);

   assign lt = (a < b);

endmodule

// File: rtl/mining_ctrl.sv
// -----------------------------------------------------------------------------
// mining_ctrl
// Walks a nonce range [start .. end] (inclusive, wrapping modulo 2^NONCE_W),
// feeding one nonce at a time to an external hash core and reporting the first
// and any later nonce whose hash is strictly below the job target.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   job_valid / job_ready    : job handshake (ready only in IDLE)
//   job_nonce_start/_end     : inclusive nonce range
//   job_target               : success threshold (hash < target wins)
//   abort                    : cancel current job (ignored in IDLE)
//   core_start / core_nonce  : one-cycle start pulse and nonce to hash core
//   core_done / core_hash    : core completion pulse and its result
//   found_valid/_ready/_nonce: winning-nonce handshake
//   exhausted                : one-cycle pulse when the range is finished
//   busy                     : high whenever not IDLE
//   hash_count               : completed-hash counter
//
// Build option
//   MINING_CTRL_STATS_EN : when defined, hash_count counts accepted core_done
//                          pulses (wraps at 2^32, cleared by rst); otherwise
//                          hash_count is tied to zero.
// -----------------------------------------------------------------------------
module mining_ctrl
   import miner_pkg::*;
#(
   parameter int NONCE_W = NONCE_W_DEF,
   parameter int HASH_W  = HASH_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [NONCE_W-1:0] job_nonce_start,
   input  logic [NONCE_W-1:0] job_nonce_end,
   input  logic [HASH_W-1:0]  job_target,
   input  logic               abort,
   output logic               core_start,
   output logic [NONCE_W-1:0] core_nonce,
   input  logic               core_done,
   input  logic [HASH_W-1:0]  core_hash,
   output logic               found_valid,
   input  logic               found_ready,
   output logic [NONCE_W-1:0] found_nonce,
   output logic               exhausted,
   output logic               busy,
   output logic [31:0]        hash_count
);

   state_t             state_reg, state_next;
   logic [NONCE_W-1:0] nonce_reg, nonce_next;
   logic [NONCE_W-1:0] end_reg, end_next;
   logic [HASH_W-1:0]  target_reg, target_next;
   logic [HASH_W-1:0]  hash_reg, hash_next;
   logic               hash_lt;
   logic               nonce_last;

   hash_cmp #(.W(HASH_W)) u_hash_cmp (
      .a  (hash_reg),
      .b  (target_reg),
      .lt (hash_lt)
   );

   assign nonce_last  = (nonce_reg == end_reg);

   // The current nonce register is held stable through ISSUE/WAIT and REPORT,
   // so it serves directly as both the core nonce and the reported nonce.
   assign core_nonce  = nonce_reg;
   assign found_nonce = nonce_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         nonce_reg  <= '0;
         end_reg    <= '0;
         target_reg <= '0;
         hash_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         nonce_reg  <= nonce_next;
         end_reg    <= end_next;
         target_reg <= target_next;
         hash_reg   <= hash_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      nonce_next  = nonce_reg;
      end_next    = end_reg;
      target_next = target_reg;
      hash_next   = hash_reg;
      job_ready   = 1'b0;
      core_start  = 1'b0;
      found_valid = 1'b0;
      exhausted   = 1'b0;
      busy        = 1'b1;

      case (state_reg)
         IDLE: begin
            busy      = 1'b0;
            job_ready = 1'b1;
            // abort has no effect on an idle controller, but a job offered in
            // the same cycle as abort is not taken.
            if (job_valid && !abort) begin
               nonce_next  = job_nonce_start;
               end_next    = job_nonce_end;
               target_next = job_target;
               state_next  = ISSUE;
            end
         end
         ISSUE: begin
            core_start = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (core_done) begin
               hash_next  = core_hash;
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (hash_lt) begin
               state_next = REPORT;
            end else if (nonce_last) begin
               state_next = DONE;
            end else begin
               nonce_next = nonce_reg + NONCE_W'(1);
               state_next = ISSUE;
            end
         end
         REPORT: begin
            found_valid = 1'b1;
            if (found_ready) begin
               if (nonce_last) begin
                  state_next = DONE;
               end else begin
                  nonce_next = nonce_reg + NONCE_W'(1);
                  state_next = ISSUE;
               end
            end
         end
         DONE: begin
            exhausted  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Cancellation wins over everything in a non-idle state; the pending
      // report and the completion pulse are withdrawn in the same cycle.
      if (abort && (state_reg != IDLE)) begin
         state_next  = IDLE;
         found_valid = 1'b0;
         exhausted   = 1'b0;
      end
   end

`ifdef MINING_CTRL_STATS_EN
   logic [31:0] hash_count_reg;

   // Only core_done pulses consumed in WAIT count; an abort in that cycle
   // discards the result, so it is not counted either.
   always_ff @(posedge clk) begin
      if (rst) begin
         hash_count_reg <= '0;
      end else if ((state_reg == WAIT) && core_done && !abort) begin
         hash_count_reg <= hash_count_reg + 32'd1;
      end
   end

   assign hash_count = hash_count_reg;
`else
   assign hash_count = '0;
`endif

endmodule

// File: tb/tb_mining_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mining_ctrl
// Scoreboard bench for mining_ctrl. Each job is expanded by a reference model
// into the ordered list of events the controller must produce (core issues,
// found reports, exhausted); a monitor pops and compares as the DUT emits them.
// A behavioural hash core answers each core_start after 2..4 cycles using a
// per-nonce hash table; a consumer holds found_ready low for 'hold' cycles.
// -----------------------------------------------------------------------------
module tb_mining_ctrl;

   localparam int NW = 32;
   localparam int HW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          job_valid;
   logic          job_ready;
   logic [NW-1:0] job_nonce_start;
   logic [NW-1:0] job_nonce_end;
   logic [HW-1:0] job_target;
   logic          abort;
   logic          core_start;
   logic [NW-1:0] core_nonce;
   logic          core_done;
   logic [HW-1:0] core_hash;
   logic          found_valid;
   logic          found_ready;
   logic [NW-1:0] found_nonce;
   logic          exhausted;
   logic          busy;
   logic [31:0]   hash_count;

   mining_ctrl #(.NONCE_W(NW), .HASH_W(HW)) dut (
      .clk             (clk),
      .rst             (rst),
      .job_valid       (job_valid),
      .job_ready       (job_ready),
      .job_nonce_start (job_nonce_start),
      .job_nonce_end   (job_nonce_end),
      .job_target      (job_target),
      .abort           (abort),
      .core_start      (core_start),
      .core_nonce      (core_nonce),
      .core_done       (core_done),
      .core_hash       (core_hash),
      .found_valid     (found_valid),
      .found_ready     (found_ready),
      .found_nonce     (found_nonce),
      .exhausted       (exhausted),
      .busy            (busy),
      .hash_count      (hash_count)
   );

   always #5 clk = ~clk;

   // event kinds: 0 = core issue, 1 = found handshake, 2 = exhausted
   typedef struct {
      int          kind;
      logic [31:0] nonce;
   } ev_t;

   ev_t           sb[$];
   logic [HW-1:0] hash_of [logic [31:0]];
   int            checks = 0;
   int            fails  = 0;
   int            cyc    = 0;
   int            hold   = 0;
   longint        exp_count = 0;
   logic [HW-1:0] cur_target = '0;
   logic [31:0]   cur_end    = '0;
   bit            accept_pending = 1'b0;
   int            accept_cyc = 0;
   bit            done_pending = 1'b0;
   int            done_cyc = 0;
   int            vcnt = 0;
   logic [31:0]   fnonce = '0;
   logic [31:0]   core_cn;
   int            core_d;
   int            wcnt = 0;

   localparam logic [HW-1:0] ALL1 = {HW{1'b1}};

   function automatic logic [HW-1:0] hval(input logic [31:0] n);
      return hash_of.exists(n) ? hash_of[n] : ALL1;
   endfunction

   function automatic logic [HW-1:0] rand256();
      logic [HW-1:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[HW-33:0], 32'($urandom)};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [HW-1:0] got, input logic [HW-1:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [31:0] n, input string nm);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL %s: unexpected event kind %0d nonce %h, nothing expected", nm, kind, n);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.nonce !== n) begin
            fails++;
            $display("FAIL %s: got kind %0d nonce %h expected kind %0d nonce %h",
                     nm, kind, n, e.kind, e.nonce);
         end else begin
            $display("ok   %s kind %0d nonce %h", nm, kind, n);
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // behavioural hash core
   initial begin
      core_done = 1'b0;
      core_hash = '0;
      forever begin
         @(negedge clk);
         if (core_start) begin
            core_cn = core_nonce;
            core_d  = $urandom_range(2, 4);
            repeat (core_d) @(posedge clk);
            #1;
            core_done = 1'b1;
            core_hash = hval(core_cn);
            @(posedge clk);
            #1;
            core_done = 1'b0;
         end
      end
   end

   // found consumer: keeps found_ready low for 'hold' cycles of found_valid
   initial begin
      found_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (found_ready) begin
            found_ready = 1'b0;
            wcnt = 0;
         end else if (found_valid) begin
            if (wcnt >= hold) found_ready = 1'b1;
            else wcnt++;
         end else begin
            wcnt = 0;
         end
      end
   end

   // monitor
   initial forever begin
      @(negedge clk);
      if (rst) begin
         vcnt = 0;
         done_pending = 1'b0;
      end else begin
         chk("job_ready_vs_busy", HW'(job_ready), HW'(!busy));
         if (core_start) begin
            expect_ev(0, core_nonce, "core_issue");
            if (accept_pending) begin
               chk("accept_to_start_latency", HW'(cyc - accept_cyc), HW'(1));
               accept_pending = 1'b0;
            end else if (done_pending) begin
               chk("done_to_start_latency", HW'(cyc - done_cyc), HW'(2));
            end
            done_pending = 1'b0;
         end
         if (found_valid) begin
            if (vcnt == 0) fnonce = found_nonce;
            vcnt++;
            if (found_ready) begin
               expect_ev(1, found_nonce, "found");
               chk("found_nonce_stable", HW'(found_nonce), HW'(fnonce));
               chk("found_valid_cycles", HW'(vcnt), HW'(hold + 1));
               vcnt = 0;
            end
         end else begin
            vcnt = 0;
         end
         if (exhausted) expect_ev(2, 32'h0, "exhausted");
         if (core_done && busy) begin
            done_pending = (core_hash >= cur_target) && (core_nonce != cur_end);
            done_cyc     = cyc;
         end
      end
   end

   function automatic logic [31:0] exp_hc();
`ifdef MINING_CTRL_STATS_EN
      return exp_count[31:0];
`else
      return 32'h0;
`endif
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      job_valid = 1'b0;
      abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_count = 0;
      @(negedge clk);
      chk("rst_job_ready",   HW'(job_ready),   HW'(1));
      chk("rst_busy",        HW'(busy),        HW'(0));
      chk("rst_core_start",  HW'(core_start),  HW'(0));
      chk("rst_found_valid", HW'(found_valid), HW'(0));
      chk("rst_exhausted",   HW'(exhausted),   HW'(0));
      chk("rst_core_nonce",  HW'(core_nonce),  HW'(0));
      chk("rst_found_nonce", HW'(found_nonce), HW'(0));
      chk("rst_hash_count",  HW'(hash_count),  HW'(exp_hc()));
      $display("ok   reset complete");
   endtask

   // kill: 0 = run to completion, 1 = abort in WAIT of nonce kat, 2 = rst there
   task automatic run_job(input logic [31:0] s, input logic [31:0] e,
                          input logic [HW-1:0] t, input int kill,
                          input logic [31:0] kat);
      logic [31:0] n;
      int          nhash;
      bit          seen;
      n = s;
      nhash = 0;
      for (int i = 0; i < 64; i++) begin
         sb.push_back('{0, n});
         if (kill != 0 && n == kat) break;
         nhash++;
         if (hval(n) < t) sb.push_back('{1, n});
         if (n == e) begin
            sb.push_back('{2, 32'h0});
            break;
         end
         n = n + 32'd1;
      end
      cur_target = t;
      cur_end    = e;
      $display("job start=%h end=%h kill=%0d at=%h hold=%0d", s, e, kill, kat, hold);

      @(posedge clk);
      #1;
      job_valid       = 1'b1;
      job_nonce_start = s;
      job_nonce_end   = e;
      job_target      = t;
      @(negedge clk);
      chk("job_ready_when_idle", HW'(job_ready), HW'(1));
      accept_cyc     = cyc;
      accept_pending = 1'b1;
      @(posedge clk);
      #1;
      job_valid       = 1'b0;
      job_nonce_start = $urandom;
      job_nonce_end   = $urandom;
      job_target      = rand256();

      if (kill != 0) begin
         seen = 1'b0;
         for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (core_start && core_nonce == kat) seen = 1'b1;
         end
         chk("kill_point_reached", HW'(seen), HW'(1));
         @(posedge clk);
         #1;
         if (kill == 1) begin
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            exp_count += nhash;
            @(negedge clk);
            chk("abort_busy",      HW'(busy),      HW'(0));
            chk("abort_job_ready", HW'(job_ready), HW'(1));
         end else begin
            do_reset();
         end
      end else begin
         exp_count += nhash;
      end

      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (!busy) seen = 1'b1;
      end
      chk("job_finished_in_time", HW'(seen), HW'(1));
      // let any late core_done from a cancelled job arrive while idle
      repeat (6) @(negedge clk);
      chk("idle_after_job",    HW'(busy),       HW'(0));
      chk("hash_count",        HW'(hash_count), HW'(exp_hc()));
      chk("scoreboard_drained", HW'(sb.size()), HW'(0));
      sb.delete();
      hash_of.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]   s;
      logic [31:0]   n;
      logic [HW-1:0] t;
      int            len;
      int            kill;
      logic [31:0]   kat;

      rst = 1'b1;
      job_valid = 1'b0;
      job_nonce_start = '0;
      job_nonce_end = '0;
      job_target = '0;
      abort = 1'b0;
      do_reset();

      // three misses, plain range
      hold = 0;
      run_job(32'h10, 32'h12, ALL1 >> 1, 0, 32'h0);

      // single hit at 7 with consumer stalling 4 cycles
      hold = 4;
      hash_of[32'h7] = '0;
      run_job(32'h5, 32'h9, ALL1 >> 1, 0, 32'h0);

      // range wrapping through zero
      hold = 0;
      run_job(32'hFFFF_FFFE, 32'h0000_0001, ALL1 >> 1, 0, 32'h0);

      // abort while waiting on nonce 3
      run_job(32'h1, 32'h6, ALL1 >> 1, 1, 32'h3);

      // hash equal to target is not a hit
      t = rand256() >> 1;
      hash_of[32'h20] = t;
      run_job(32'h20, 32'h20, t, 0, 32'h0);

      // hit on the last nonce of the range
      hold = 1;
      hash_of[32'h31] = '0;
      run_job(32'h30, 32'h31, ALL1 >> 1, 0, 32'h0);

      // three-hash job, then reset clears the counter
      hold = 0;
      run_job(32'h100, 32'h102, ALL1 >> 1, 0, 32'h0);
      do_reset();

      // reset in the middle of a job; late core_done must be ignored
      run_job(32'h40, 32'h48, ALL1 >> 1, 2, 32'h42);

      // randomized jobs
      for (int r = 0; r < 14; r++) begin
         s   = (r % 3 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : 32'($urandom);
         len = $urandom_range(1, 6);
         t   = {1'b0, rand256() >> 1};
         n   = s;
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 3))
               0: hash_of[n] = t;
               1: hash_of[n] = t - HW'(1);
               2: hash_of[n] = ALL1;
               default: hash_of[n] = rand256();
            endcase
            n = n + 32'd1;
         end
         hold = $urandom_range(0, 3);
         kill = (r % 4 == 3) ? 1 : 0;
         kat  = s + 32'($urandom_range(0, len - 1));
         run_job(s, s + 32'(len - 1), t, kill, kat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
